cdc_fifo_write_state: RTL
=========================

# cdc_fifo_write_state

Write-domain pointer and flag logic for the dual-clock FIFO. It holds the write address, publishes it Gray-coded to the read domain, and synchronises the read domain's Gray read pointer into the write clock. From that it derives `full`, `almost_full` and occupancy. It sits directly upstream of `cdc_fifo_read_state`: its `write_address_gray` is that block's `write_address_gray` input, and its `write_address`/`write_enable` drive the FIFO storage write port.

## Interface
- `ADDRESS_WIDTH`, 4 — pointer/address width; capacity is 2^ADDRESS_WIDTH − 1 entries (one slot reserved, matching the read side's `empty = equal` rule).
- `SYNC_STAGES`, 2 — flops in the read-pointer synchroniser; legal values ≥ 2.
- `ALMOST_FULL_THRESHOLD`, 12 — `almost_full` asserts when occupancy ≥ this value; legal range 1 .. 2^ADDRESS_WIDTH − 1.

Ports:
- `clock`  in  1  write-domain clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `increment`  in  1  write request for this cycle.
- `read_address_gray`  in  ADDRESS_WIDTH  Gray read pointer from the read domain; asynchronous to `clock`.
- `write_address`  out  ADDRESS_WIDTH  binary write address to storage.
- `write_address_gray`  out  ADDRESS_WIDTH  registered Gray write pointer to the read domain.
- `write_enable`  out  1  storage write strobe, `increment & !full`.
- `full`  out  1  no free slot.
- `almost_full`  out  1  occupancy ≥ `ALMOST_FULL_THRESHOLD`.
- `used`  out  ADDRESS_WIDTH  occupancy as seen from the write domain.
- `overflow`  out  1  sticky push-while-full flag; present only with the macro.

## Operation
- **Synchroniser:** `read_address_gray` passes through a `SYNC_STAGES`-deep flop chain. The last stage is decoded Gray→binary to give `read_address_sync`.
- **Occupancy:** `used = (write_address − read_address_sync) mod 2^ADDRESS_WIDTH`.
- **Flags:**
  - `full = (used == 2^ADDRESS_WIDTH − 1)`.
  - `almost_full = (used ≥ ALMOST_FULL_THRESHOLD)`.
  - `full`, `almost_full`, `used` and `write_enable` are combinational from registers only (plus `increment` for `write_enable`).
- **Push accept:**
  - When `increment & !full`: `write_address` increments by 1, wrapping 2^ADDRESS_WIDTH − 1 → 0.
  - On the same edge, `write_address_gray` loads gray(next `write_address`).
- **Push reject:** `increment` while `full` is dropped. Address and Gray pointer hold.
- **Gray output:** always a flop output, never combinational, so the read domain sees exactly one bit change per accepted push.
- **Pessimism:** `full` and `used` are conservative. Pops appear only after synchroniser latency, so the block never reports free space that does not exist.
- **Reset:**
  - At a `clock` edge with `reset` high, the following clear to 0: `write_address`, `write_address_gray`, all synchroniser stages and `overflow`.
  - `increment` is ignored in that cycle.
  - This applies mid-operation as well.
  - The system resets both FIFO domains together.

## Timing
- Reset values: `write_address` = 0, `write_address_gray` = 0, `used` = 0, `full` = 0, `almost_full` = 0, `write_enable` = `increment`, `overflow` = 0.
- Accepted push at edge N: `write_address`, `write_address_gray` and `used` are updated after edge N. The flags reflect the new occupancy in cycle N+1.
- A change on `read_address_gray` stable before edge M is reflected in `used`/`full` after edge M + SYNC_STAGES − 1.
- A simultaneous push and pop-visibility in the same cycle gives a net occupancy change of 0. `full` may stay deasserted.

## Configuration
- `CDC_FIFO_WRITE_OVERFLOW_EN` defined:
  - `overflow` port and register are present.
  - `overflow` sets on any edge where `increment & full` and stays set until `reset`.
- `CDC_FIFO_WRITE_OVERFLOW_EN` undefined:
  - The port is absent.
  - Rejected pushes are silently dropped.
  - All other behaviour is identical.

## Test plan
- **Reset:** hold `increment` = 1 through reset.
  - Required: after reset `write_address` = 0, `write_address_gray` = 0, `used` = 0, `full` = 0, `write_enable` = 1.
- **Fill:** `read_address_gray` = 0, 15 pushes.
  - After the 15th: `write_address` = 15, `write_address_gray` = 4'b1000, `full` = 1.
  - 16th push: `write_enable` = 0, address stays 15, `overflow` = 1 (macro on).
- **Almost full (threshold 12):**
  - After 11 pushes: `almost_full` = 0.
  - After 12 pushes: `almost_full` = 1, `used` = 12.
- **Sync latency:** from full (`write_address` = 15), set `read_address_gray` = 4'b0010 (binary 3).
  - `full` stays 1 for exactly 1 cycle (SYNC_STAGES − 1 = 1), then `full` = 0 and `used` = 12.
- **Wrap-around:** `read_address_gray` = gray(13), `write_address` = 14, push 4 times.
  - Addresses go 15, 0, 1, 2; Gray goes 1000 → 0000 (single bit change); `used` goes 2, 3, 4, 5.
- **Reset mid-fill:** assert `reset` for one cycle with `increment` = 1 after 7 pushes.
  - All outputs at reset values; the next push gives `write_address` = 1.

Source files
------------

// File: rtl/cdc_fifo_write_state.sv
// Write-domain pointer/flag logic of the dual-clock FIFO: Gray write pointer out, synchronised Gray read pointer in.
// Optional sticky overflow flag enabled by defining CDC_FIFO_WRITE_OVERFLOW_EN.
module cdc_fifo_write_state #(
    parameter int ADDRESS_WIDTH         = 4,
    parameter int SYNC_STAGES           = 2,   // must be >= 2
    parameter int ALMOST_FULL_THRESHOLD = 12   // 1 .. 2^ADDRESS_WIDTH-1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     increment,
    input  logic [ADDRESS_WIDTH-1:0] read_address_gray,
    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic [ADDRESS_WIDTH-1:0] write_address_gray,
    output logic                     write_enable,
    output logic                     full,
    output logic                     almost_full,
    output logic [ADDRESS_WIDTH-1:0] used
`ifdef CDC_FIFO_WRITE_OVERFLOW_EN
    ,
    output logic                     overflow
`endif
);

    localparam logic [ADDRESS_WIDTH:0] ALMOST_FULL_LEVEL = ALMOST_FULL_THRESHOLD[ADDRESS_WIDTH:0];

    logic [ADDRESS_WIDTH-1:0] sync_chain [SYNC_STAGES];
    logic [ADDRESS_WIDTH-1:0] read_address_sync;
    logic [ADDRESS_WIDTH-1:0] next_address;
    logic [ADDRESS_WIDTH-1:0] next_gray;

    function automatic logic [ADDRESS_WIDTH-1:0] gray_to_binary(input logic [ADDRESS_WIDTH-1:0] g);
        logic [ADDRESS_WIDTH-1:0] b;
        b[ADDRESS_WIDTH-1] = g[ADDRESS_WIDTH-1];
        for (int i = ADDRESS_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Stage 0 is the only flop that samples the asynchronous read pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= '0;
            end
        end else begin
            sync_chain[0] <= read_address_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
        end
    end

    assign read_address_sync = gray_to_binary(sync_chain[SYNC_STAGES-1]);

    // Occupancy uses a delayed read pointer, so it can only over-estimate.
    assign used         = write_address - read_address_sync;
    assign full         = (used == {ADDRESS_WIDTH{1'b1}});
    assign almost_full  = ({1'b0, used} >= ALMOST_FULL_LEVEL);
    assign write_enable = increment & ~full;

    assign next_address = write_address + ADDRESS_WIDTH'(1);
    assign next_gray    = next_address ^ (next_address >> 1);

    // Gray pointer is registered so the read domain never sees combinational glitches.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_address      <= '0;
            write_address_gray <= '0;
        end else if (write_enable) begin
            write_address      <= next_address;
            write_address_gray <= next_gray;
        end
    end

`ifdef CDC_FIFO_WRITE_OVERFLOW_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (increment & full) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule
